// File: rtl/fcvt_ws_if.sv
// Handshake and data bundle between the FP execute stage and the float-to-int converter.
// Carries no state and adds no latency.
// Backpressure: the requester must hold off start while busy is high; starts issued then are dropped.
// Optional fflags signal is present when FCVT_WS_FFLAGS_EN is defined.
interface fcvt_ws_if;
  logic        start;
  logic [31:0] rs1;
  logic        is_unsigned;
  logic [2:0]  rm;
  logic        busy;
  logic        valid;
  logic [31:0] out;
`ifdef FCVT_WS_FFLAGS_EN
  logic [4:0]  fflags;
`endif

  modport master (
    output start, rs1, is_unsigned, rm,
    input  busy, valid, out
`ifdef FCVT_WS_FFLAGS_EN
    , fflags
`endif
  );

  modport slave (
    input  start, rs1, is_unsigned, rm,
    output busy, valid, out
`ifdef FCVT_WS_FFLAGS_EN
    , fflags
`endif
  );
endinterface

// File: rtl/fcvt_ws.sv
// Purpose: IEEE-754 single to signed/unsigned int32 (FCVT.W.S / FCVT.WU.S), RISC-V rounding and saturation.
// Latency: specials valid after edge 2, normal after edge 3+ceil(sh/SHIFT_STEP) from the accepting edge.
// Backpressure: one op in flight; start ignored while busy (including the valid cycle).
// Optional: define FCVT_WS_FFLAGS_EN to add the fflags output (NV=bit4, NX=bit0).
module fcvt_ws #(
  parameter int SHIFT_STEP = 4
) (
  input  logic     clk,
  input  logic     resetn,
  fcvt_ws_if.slave bus
);

  typedef enum logic [2:0] {IDLE, UNPACK, SHIFT, ROUND, DONE} state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic [31:0] out_q, out_d;
  logic        s_q, s_d;
  logic [7:0]  e_q, e_d;
  logic [22:0] f_q, f_d;
  logic        uns_q, uns_d;
  logic [2:0]  rm_q, rm_d;
  // mag holds the working magnitude and, after ROUND, the final result
  logic [32:0] mag_q, mag_d;
  logic        g_q, g_d;
  logic        st_q, st_d;
  logic [4:0]  sh_q, sh_d;
  logic        left_q, left_d;
`ifdef FCVT_WS_FFLAGS_EN
  logic        nv_q, nv_d;
  logic        nx_q, nx_d;
  logic [4:0]  fflags_q, fflags_d;
`endif

  logic        is_nan, is_zero, is_big;
  logic [31:0] sat_t;
  logic [32:0] mag_t;
  logic        g_t, st_t;
  logic        inc_t;
  logic [32:0] r_t;
  logic [31:0] res_t;

  // Next-state and datapath: unpack, iterative shift, round/saturate, publish
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    out_d   = out_q;
    s_d     = s_q;
    e_d     = e_q;
    f_d     = f_q;
    uns_d   = uns_q;
    rm_d    = rm_q;
    mag_d   = mag_q;
    g_d     = g_q;
    st_d    = st_q;
    sh_d    = sh_q;
    left_d  = left_q;
`ifdef FCVT_WS_FFLAGS_EN
    nv_d     = nv_q;
    nx_d     = nx_q;
    fflags_d = fflags_q;
`endif
    is_nan  = (e_q == 8'hFF) && (f_q != 23'd0);
    is_zero = (e_q == 8'd0) && (f_q != 23'd0) == 1'b0;
    is_big  = (e_q >= 8'd159);
    mag_t   = mag_q;
    g_t     = g_q;
    st_t    = st_q;
    inc_t   = 1'b0;
    r_t     = 33'd0;
    res_t   = 32'd0;

    // NaN always saturates positive; inf/huge saturate by sign
    if (is_nan || !s_q) sat_t = uns_q ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
    else                sat_t = uns_q ? 32'h0000_0000 : 32'h8000_0000;

    // busy stays up through the valid cycle so a start there is dropped
    if (valid_q) busy_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && !busy_q) begin
          s_d     = bus.rs1[31];
          e_d     = bus.rs1[30:23];
          f_d     = bus.rs1[22:0];
          uns_d   = bus.is_unsigned;
          rm_d    = bus.rm;
          busy_d  = 1'b1;
          state_d = UNPACK;
        end
      end

      UNPACK: begin
        mag_d = {9'd0, (e_q != 8'd0), f_q};
        g_d   = 1'b0;
        st_d  = 1'b0;
        if (is_zero) begin
          mag_d   = 33'd0;
          state_d = DONE;
`ifdef FCVT_WS_FFLAGS_EN
          nv_d = 1'b0;
          nx_d = 1'b0;
`endif
        end else if (is_big) begin
          mag_d   = {1'b0, sat_t};
          state_d = DONE;
`ifdef FCVT_WS_FFLAGS_EN
          nv_d = 1'b1;
          nx_d = 1'b0;
`endif
        end else if (e_q >= 8'd150) begin
          left_d  = 1'b1;
          sh_d    = 5'(e_q - 8'd150);
          state_d = (e_q == 8'd150) ? ROUND : SHIFT;
        end else begin
          // anything shifted past 26 places lands entirely in sticky anyway
          left_d  = 1'b0;
          sh_d    = (e_q < 8'd124) ? 5'd26 : 5'(8'd150 - e_q);
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        for (int i = 0; i < SHIFT_STEP; i++) begin
          if (5'(i) < sh_q) begin
            if (left_q) begin
              mag_t = {mag_t[31:0], 1'b0};
            end else begin
              st_t  = st_t | g_t;
              g_t   = mag_t[0];
              mag_t = {1'b0, mag_t[32:1]};
            end
          end
        end
        mag_d   = mag_t;
        g_d     = g_t;
        st_d    = st_t;
        sh_d    = (sh_q > 5'(SHIFT_STEP)) ? (sh_q - 5'(SHIFT_STEP)) : 5'd0;
        state_d = (sh_d == 5'd0) ? ROUND : SHIFT;
      end

      ROUND: begin
        case (rm_q)
          3'b000:  inc_t = g_q & (st_q | mag_q[0]);
          3'b010:  inc_t = s_q & (g_q | st_q);
          3'b011:  inc_t = ~s_q & (g_q | st_q);
          3'b100:  inc_t = g_q;
          default: inc_t = 1'b0;
        endcase
        r_t   = mag_q + {32'd0, inc_t};
        res_t = r_t[31:0];
        if (uns_q) begin
          if (s_q)         res_t = 32'd0;
          else if (r_t[32]) res_t = 32'hFFFF_FFFF;
        end else begin
          if (s_q) begin
            if (r_t > 33'h0_8000_0000) res_t = 32'h8000_0000;
            else                       res_t = ~r_t[31:0] + 32'd1;
          end else if (r_t > 33'h0_7FFF_FFFF) begin
            res_t = 32'h7FFF_FFFF;
          end
        end
        mag_d   = {1'b0, res_t};
        state_d = DONE;
`ifdef FCVT_WS_FFLAGS_EN
        nv_d = uns_q ? (s_q ? (r_t != 33'd0) : r_t[32])
                     : (s_q ? (r_t > 33'h0_8000_0000) : (r_t > 33'h0_7FFF_FFFF));
        nx_d = (g_q | st_q) & ~nv_d;
`endif
      end

      DONE: begin
        out_d   = mag_q[31:0];
        valid_d = 1'b1;
        state_d = IDLE;
`ifdef FCVT_WS_FFLAGS_EN
        fflags_d = {nv_q, 3'b000, nx_q};
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any conversion in flight
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      out_q   <= 32'd0;
      s_q     <= 1'b0;
      e_q     <= 8'd0;
      f_q     <= 23'd0;
      uns_q   <= 1'b0;
      rm_q    <= 3'd0;
      mag_q   <= 33'd0;
      g_q     <= 1'b0;
      st_q    <= 1'b0;
      sh_q    <= 5'd0;
      left_q  <= 1'b0;
`ifdef FCVT_WS_FFLAGS_EN
      nv_q     <= 1'b0;
      nx_q     <= 1'b0;
      fflags_q <= 5'd0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      s_q     <= s_d;
      e_q     <= e_d;
      f_q     <= f_d;
      uns_q   <= uns_d;
      rm_q    <= rm_d;
      mag_q   <= mag_d;
      g_q     <= g_d;
      st_q    <= st_d;
      sh_q    <= sh_d;
      left_q  <= left_d;
`ifdef FCVT_WS_FFLAGS_EN
      nv_q     <= nv_d;
      nx_q     <= nx_d;
      fflags_q <= fflags_d;
`endif
    end
  end

  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;
  assign bus.out   = out_q;
`ifdef FCVT_WS_FFLAGS_EN
  assign bus.fflags = fflags_q;
`endif

endmodule
